// File: rtl/snd_pkg.sv
// snd_pkg: shared state encoding and counter-width helper for the sound command scheduler
package snd_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, IRQ, WAIT_RD, GAP} state_e;
  function automatic int cnt_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/snd_cmd_fifo.sv
// snd_cmd_fifo: DEPTHx8 synchronous FIFO with flush; a full FIFO still accepts a push paired with a pop
module snd_cmd_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nU115_CLR,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  always_comb begin
    rd = pop & ~empty & ~flush;
    wr = push & (~full | rd) & ~flush;
    wp_d = flush ? '0 : wp_q + AW'(wr);
    rp_d = flush ? '0 : rp_q + AW'(rd);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  always_ff @(posedge clk or negedge nU115_CLR)
    if (!nU115_CLR) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= din;
  assign dout = mem_q[rp_q];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/snd_cmd_sched.sv
// snd_cmd_sched: queues main-CPU sound commands and hands them one at a time to the Z80
// through a single latch and interrupt, waiting for acknowledge and latch read in between.
module snd_cmd_sched import snd_pkg::*; #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 4096,
  parameter int RETRY_MAX  = 3
) (
  input  logic                     clk,
  input  logic                     nU115_CLR,
  input  logic                     cmd_we,
  input  logic [7:0]               cmd_d,
  input  logic                     int_ack,
  input  logic                     latch_rd,
  input  logic                     flush,
  output logic [7:0]               latch_q,
  output logic                     nint,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ovf,
  output logic                     drop
);
  localparam int TW = cnt_w(TIMEOUT);
  localparam int GW = cnt_w(GAP_CYCLES);
  localparam int RW = cnt_w(RETRY_MAX + 1);
  state_e state_q, state_d;
  logic [7:0] lat_q, lat_d, head;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [RW-1:0] rty_q, rty_d;
  logic nint_q, nint_d, ovf_q, ovf_d, drop_q, drop_d;
  logic push, pop, full, empty;
  snd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .nU115_CLR(nU115_CLR), .push(push), .pop(pop), .flush(flush),
    .din(cmd_d), .dout(head), .full(full), .empty(empty), .count(fifo_count)
  );
  always_comb begin
    push = cmd_we & ~flush;
    pop = state_q == LOAD;
    state_d = state_q;
    lat_d = lat_q;
    tmr_d = '0;
    gap_d = '0;
    rty_d = rty_q;
    drop_d = drop_q;
    ovf_d = ovf_q | (push & full & ~pop);
    unique case (state_q)
      IDLE: state_d = empty ? IDLE : LOAD;
      LOAD: begin
        lat_d = head;
        rty_d = '0;
        state_d = IRQ;
      end
      // a read while still interrupting comes from polling software: it is both ack and read
      IRQ: state_d = latch_rd ? GAP : int_ack ? WAIT_RD : IRQ;
      WAIT_RD:
        if (latch_rd) state_d = GAP;
        else if (tmr_q != TW'(TIMEOUT - 1)) tmr_d = tmr_q + TW'(1);
        else if (rty_q < RW'(RETRY_MAX)) begin
          rty_d = rty_q + RW'(1);
          state_d = IRQ;
        end else begin
          drop_d = 1'b1;
          state_d = GAP;
        end
      GAP:
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_d = gap_q + GW'(1);
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      lat_d = lat_q;
      drop_d = drop_q;
      tmr_d = '0;
      gap_d = '0;
    end
    // the request goes low one cycle after IRQ is entered and lifts on the edge that leaves IRQ
    nint_d = !(state_q == IRQ && state_d == IRQ);
  end
  always_ff @(posedge clk or negedge nU115_CLR)
    if (!nU115_CLR) begin
      state_q <= IDLE;
      lat_q <= '0;
      tmr_q <= '0;
      gap_q <= '0;
      rty_q <= '0;
      nint_q <= 1'b1;
      ovf_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
      tmr_q <= tmr_d;
      gap_q <= gap_d;
      rty_q <= rty_d;
      nint_q <= nint_d;
      ovf_q <= ovf_d;
      drop_q <= drop_d;
    end
  assign latch_q = lat_q;
  assign nint = nint_q;
  assign busy = state_q != IDLE;
  assign ovf = ovf_q;
  assign drop = drop_q;
endmodule

// File: tb/tb_snd_cmd_sched.sv
// tb_snd_cmd_sched: randomized scoreboard bench with a transaction-level model of the scheduler
module tb_snd_cmd_sched;
  localparam int DEPTH = 4, GAP = 16, TMO = 64, RMAX = 3;
  logic clk = 0, nU115_CLR = 0, cmd_we = 0, int_ack = 0, latch_rd = 0, flush = 0;
  logic [7:0] cmd_d = 0, latch_q;
  logic nint, busy, ovf, drop;
  logic [2:0] fifo_count;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;

  snd_cmd_sched #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO), .RETRY_MAX(RMAX)) dut (
    .clk(clk), .nU115_CLR(nU115_CLR), .cmd_we(cmd_we), .cmd_d(cmd_d), .int_ack(int_ack),
    .latch_rd(latch_rd), .flush(flush), .latch_q(latch_q), .nint(nint), .busy(busy),
    .fifo_count(fifo_count), .ovf(ovf), .drop(drop)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
  endtask

  // Reference: a queue of stored bytes plus one command "in service" described by timestamps.
  typedef enum {S_NONE, S_LOADING, S_ASKING, S_WAITING} svc_e;
  svc_e svc;
  int e, idle_from, ask_e, due, tries;
  logic [7:0] mq[$], pres[$], cur, m_latch;
  bit m_ovf, m_drop, m_busy, m_nint;
  initial forever begin
    @(posedge clk or negedge nU115_CLR);
    if (!nU115_CLR) begin
      svc = S_NONE; e = 0; idle_from = 0; mq.delete();
      m_latch = 0; m_ovf = 0; m_drop = 0;
    end else begin
      e++;
      if (flush) begin
        mq.delete(); svc = S_NONE; idle_from = e;
      end else begin
        case (svc)
          S_NONE: if (e > idle_from && mq.size() > 0) svc = S_LOADING;
          S_LOADING: begin
            cur = mq.pop_front(); m_latch = cur; tries = 0;
            svc = S_ASKING; ask_e = e; pres.push_back(cur);
          end
          S_ASKING:
            if (latch_rd) begin svc = S_NONE; idle_from = e + GAP; end
            else if (int_ack) begin svc = S_WAITING; due = e + TMO; end
          S_WAITING:
            if (latch_rd) begin svc = S_NONE; idle_from = e + GAP; end
            else if (e == due) begin
              if (tries < RMAX) begin tries++; svc = S_ASKING; ask_e = e; pres.push_back(cur); end
              else begin m_drop = 1; svc = S_NONE; idle_from = e + GAP; end
            end
        endcase
        if (cmd_we) begin
          if (mq.size() < DEPTH) mq.push_back(cmd_d);
          else m_ovf = 1;
        end
      end
    end
    m_busy = svc != S_NONE || e < idle_from;
    m_nint = !(svc == S_ASKING && ask_e < e);
  end

  // Monitor: status every cycle; each falling nint pops the next expected presentation.
  int pres_rd = 0, nfalls = 0;
  logic nint_prev = 1;
  initial forever begin
    @(negedge clk or negedge nU115_CLR);
    if (!nU115_CLR) begin
      pres_rd = pres.size(); nint_prev = 1;
    end else begin
      check("fifo_count", fifo_count, mq.size());
      check("busy", busy, m_busy);
      check("nint", nint, m_nint);
      check("latch_q", latch_q, m_latch);
      check("ovf", ovf, m_ovf);
      check("drop", drop, m_drop);
      if (nint_prev && !nint) begin
        nfalls++;
        if (pres_rd < pres.size()) begin
          check("presented byte", latch_q, pres[pres_rd]); pres_rd++;
        end else check("irq with nothing expected", pres.size() - pres_rd, 1);
      end
      nint_prev = nint;
    end
  end

  // Z80 responder: acks after a short random delay, then reads, or polls with a bare read.
  bit z_en = 1, z_poll = 0;
  int z_mode = 0, z_st = 0, z_cnt = 0;
  initial forever begin
    @(negedge clk);
    int_ack = 0; latch_rd = 0;
    if (!nU115_CLR) z_st = 0;
    else if (z_st == 0) begin
      if (z_en && nint === 1'b0) begin
        z_st = 1; z_cnt = $urandom_range(3); z_poll = z_mode == 0 && $urandom_range(4) == 0;
      end
    end else if (z_st == 1) begin
      if (z_cnt > 0) z_cnt--;
      else if (z_poll) begin latch_rd = 1; z_st = 0; end
      else begin int_ack = 1; z_st = z_mode == 0 ? 2 : 0; z_cnt = $urandom_range(20); end
    end else begin
      if (z_cnt > 0) z_cnt--;
      else begin latch_rd = 1; z_st = 0; end
    end
  end

  task automatic push(input logic [7:0] b);
    cmd_we = 1; cmd_d = b;
    @(negedge clk);
    cmd_we = 0;
  endtask

  task automatic wait_idle(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!busy && fifo_count == 0 && z_st == 0) begin ok = 1; break; end
    end
    check("reached idle", ok, 1);
  endtask

  task automatic wait_nint(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (nint === 1'b0) begin ok = 1; break; end
      @(negedge clk);
    end
    check("nint asserted", ok, 1);
  endtask

  initial begin
    int n, f0;
    repeat (3) @(negedge clk);
    check("rst latch_q", latch_q, 0);
    check("rst nint", nint, 1);
    check("rst busy", busy, 0);
    check("rst fifo_count", fifo_count, 0);
    check("rst ovf", ovf, 0);
    check("rst drop", drop, 0);
    nU115_CLR = 1;
    @(negedge clk);
    // single command: nint three edges after the push edge
    push(8'h5A);
    n = 0;
    while (nint !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    check("irq latency", n, 3);
    check("first latch", latch_q, 8'h5A);
    wait_idle(200);
    check("idle busy", busy, 0);
    // back-to-back commands presented in order
    push(8'h01); push(8'h02); push(8'h03);
    wait_idle(400);
    // overflow while stalled in IRQ
    z_en = 0;
    push(8'h0F);
    wait_nint(20);
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    check("ovf set", ovf, 1);
    check("fifo full count", fifo_count, 4);
    z_en = 1;
    wait_idle(800);
    // acknowledge without read: three re-asserts, then drop and move on
    z_mode = 1; f0 = nfalls;
    push(8'hA1); push(8'hA2);
    n = 0;
    while (drop !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    z_mode = 0;
    check("drop set", drop, 1);
    check("irq pulses before drop", nfalls - f0, 4);
    wait_idle(300);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cmd_we = $urandom_range(9) == 0; cmd_d = 8'($urandom);
      @(negedge clk);
    end
    cmd_we = 0;
    wait_idle(3000);
    // flush in WAIT_RD together with a write
    z_mode = 1;
    push(8'h33);
    wait_nint(20);
    repeat (6) @(negedge clk);
    flush = 1; cmd_we = 1; cmd_d = 8'h77;
    @(negedge clk);
    flush = 0; cmd_we = 0; z_mode = 0;
    check("flush busy", busy, 0);
    check("flush count", fifo_count, 0);
    check("flush latch kept", latch_q, 8'h33);
    repeat (5) @(negedge clk);
    check("flushed byte absent", fifo_count, 0);
    // asynchronous reset mid-operation
    z_en = 0;
    push(8'h61); push(8'h62); push(8'h63);
    wait_nint(20);
    check("queued before reset", fifo_count, 2);
    @(posedge clk);
    #2 nU115_CLR = 0;
    #1;
    check("async nint", nint, 1);
    check("async count", fifo_count, 0);
    check("async latch", latch_q, 0);
    check("async ovf", ovf, 0);
    check("async drop", drop, 0);
    @(negedge clk);
    nU115_CLR = 1; z_en = 1;
    repeat (5) @(negedge clk);
    check("all irqs seen", pres_rd, pres.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
